// File: rtl/flag_event_monitor_if.sv
// Flag event monitor bus: raw flag and controls in, filtered level,
// event handshake and statistics out.
interface flag_event_monitor_if #(
    parameter int unsigned CNT_W = 8
);

    logic             flag_in;
    logic             clr_cnt;
    logic             evt_ack;
    logic             flag_stable;
    logic             evt_valid;
    logic [CNT_W-1:0] evt_count;
    logic             overrun;

    modport master (
        output flag_in,
        output clr_cnt,
        output evt_ack,
        input  flag_stable,
        input  evt_valid,
        input  evt_count,
        input  overrun
    );

    modport slave (
        input  flag_in,
        input  clr_cnt,
        input  evt_ack,
        output flag_stable,
        output evt_valid,
        output evt_count,
        output overrun
    );

endinterface

// File: rtl/flag_event_monitor.sv
// Debounces a raw flag, reports qualified rising edges over valid/ack,
// and keeps a saturating event count plus a sticky overrun flag.
module flag_event_monitor #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input logic                 clk,
    input logic                 rst,
    flag_event_monitor_if.slave bus
);

    localparam int unsigned QW = $clog2(STABLE_CYCLES + 1);

    localparam logic [QW-1:0]    QMAX = QW'(STABLE_CYCLES);
    localparam logic [QW-1:0]    QONE = QW'(1);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RISE_Q,
        HIGH,
        FALL_Q
    } state_t;

    state_t           state_q, state_d;
    logic [QW-1:0]    qcnt_q, qcnt_d;
    logic [QW-1:0]    qinc;
    logic             flag_stable_q, flag_stable_d;
    logic             evt_valid_q, evt_valid_d;
    logic [CNT_W-1:0] evt_count_q, evt_count_d;
    logic             overrun_q, overrun_d;
    logic             rise;

    // Debounce: qcnt tracks consecutive samples that disagree with
    // the stable level, counting the current edge.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        rise    = 1'b0;
        qinc    = qcnt_q + QONE;
        unique case (state_q)
            IDLE: begin
                if (bus.flag_in) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = HIGH;
                        qcnt_d  = '0;
                        rise    = 1'b1;
                    end else begin
                        state_d = RISE_Q;
                        qcnt_d  = QONE;
                    end
                end
            end
            RISE_Q: begin
                if (!bus.flag_in) begin
                    state_d = IDLE;
                    qcnt_d  = '0;
                end else if (qinc == QMAX) begin
                    state_d = HIGH;
                    qcnt_d  = '0;
                    rise    = 1'b1;
                end else begin
                    qcnt_d  = qinc;
                end
            end
            HIGH: begin
                if (!bus.flag_in) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = IDLE;
                        qcnt_d  = '0;
                    end else begin
                        state_d = FALL_Q;
                        qcnt_d  = QONE;
                    end
                end
            end
            FALL_Q: begin
                // Returning high here is a glitch, not a new event
                if (bus.flag_in) begin
                    state_d = HIGH;
                    qcnt_d  = '0;
                end else if (qinc == QMAX) begin
                    state_d = IDLE;
                    qcnt_d  = '0;
                end else begin
                    qcnt_d  = qinc;
                end
            end
            default: begin
                state_d = IDLE;
                qcnt_d  = '0;
            end
        endcase
    end

    assign flag_stable_d = (state_d == HIGH) || (state_d == FALL_Q);

    // A coincident ack retires the old event, so the new one is clean
    always_comb begin
        evt_valid_d = rise | (evt_valid_q & ~bus.evt_ack);
        overrun_d   = overrun_q;
        evt_count_d = evt_count_q;
        if (rise && evt_valid_q && !bus.evt_ack) begin
            overrun_d = 1'b1;
        end
        if (rise && (evt_count_q != CMAX)) begin
            evt_count_d = evt_count_q + CONE;
        end
        if (bus.clr_cnt) begin
            overrun_d   = 1'b0;
            evt_count_d = rise ? CONE : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            qcnt_q        <= '0;
            flag_stable_q <= 1'b0;
            evt_valid_q   <= 1'b0;
            evt_count_q   <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            qcnt_q        <= qcnt_d;
            flag_stable_q <= flag_stable_d;
            evt_valid_q   <= evt_valid_d;
            evt_count_q   <= evt_count_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.flag_stable = flag_stable_q;
    assign bus.evt_valid   = evt_valid_q;
    assign bus.evt_count   = evt_count_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_flag_event_monitor.sv
// Bench for flag_event_monitor: run-length debounce model checked
// every cycle, plus literal checkpoints from hand-worked sequences.
module tb_flag_event_monitor;

    localparam int S     = 4;
    localparam int CW    = 8;
    localparam int SAT   = (1 << CW) - 1;

    logic clk;
    logic rst;

    int n_cmp = 0;
    int n_bad = 0;

    flag_event_monitor_if #(.CNT_W(CW)) bus ();

    flag_event_monitor #(
        .STABLE_CYCLES(S),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: level flips after S consecutive disagreeing samples
    bit m_stable;
    int m_run;
    bit m_valid;
    int m_count;
    bit m_ovr;
    bit ev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_stable = 0;
            m_run    = 0;
            m_valid  = 0;
            m_count  = 0;
            m_ovr    = 0;
        end else begin
            ev = 0;
            if (bus.flag_in != m_stable) begin
                m_run++;
                if (m_run == S) begin
                    m_stable = bus.flag_in;
                    m_run    = 0;
                    ev       = bus.flag_in;
                end
            end else begin
                m_run = 0;
            end
            if (ev) begin
                if (m_valid && !bus.evt_ack) m_ovr = 1;
                m_valid = 1;
                if (m_count < SAT) m_count++;
            end else if (m_valid && bus.evt_ack) begin
                m_valid = 0;
            end
            if (bus.clr_cnt) begin
                m_count = ev ? 1 : 0;
                m_ovr   = 0;
            end
        end
    end

    task automatic cmp(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d @%0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            cmp("model flag_stable", int'(bus.flag_stable), int'(m_stable));
            cmp("model evt_valid", int'(bus.evt_valid), int'(m_valid));
            cmp("model evt_count", int'(bus.evt_count), m_count);
            cmp("model overrun", int'(bus.overrun), int'(m_ovr));
        end
    end

    task automatic step(bit f, bit a, bit c);
        bus.flag_in = f;
        bus.evt_ack = a;
        bus.clr_cnt = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ev_seq(bit a_last, bit c_last);
        repeat (S - 1) step(1, 0, 0);
        step(1, a_last, c_last);
        repeat (S) step(0, 0, 0);
    endtask

    task automatic lit(string nm, int sv, int vv, int cv, int ov);
        cmp({nm, " flag_stable"}, int'(bus.flag_stable), sv);
        cmp({nm, " evt_valid"}, int'(bus.evt_valid), vv);
        cmp({nm, " evt_count"}, int'(bus.evt_count), cv);
        cmp({nm, " overrun"}, int'(bus.overrun), ov);
    endtask

    task automatic async_rst(string nm);
        rst = 1'b1;
        #1;
        lit(nm, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.flag_in = 1'b0;
        bus.evt_ack = 1'b0;
        bus.clr_cnt = 1'b0;
        #1;
        lit("reset", 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Short high burst never qualifies
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            lit("short high", 0, 0, 0, 0);
        end
        step(0, 0, 0);
        lit("short end", 0, 0, 0, 0);
        repeat (3) step(0, 0, 0);

        // Qualified rise, then ack
        repeat (3) step(1, 0, 0);
        lit("rise pre", 0, 0, 0, 0);
        step(1, 0, 0);
        lit("rise qual", 1, 1, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        lit("rise hold", 1, 1, 1, 0);
        step(1, 1, 0);
        lit("ack", 1, 0, 1, 0);

        // Low glitch filtered, then qualified fall
        repeat (3) step(0, 0, 0);
        lit("glitch low", 1, 0, 1, 0);
        step(1, 0, 0);
        lit("glitch back", 1, 0, 1, 0);
        repeat (3) step(0, 0, 0);
        lit("fall pre", 1, 0, 1, 0);
        step(0, 0, 0);
        lit("fall qual", 0, 0, 1, 0);

        // Overrun without ack, then event+ack on the same edge
        step(0, 0, 1);
        lit("clr", 0, 0, 0, 0);
        ev_seq(0, 0);
        lit("ev1", 0, 1, 1, 0);
        ev_seq(0, 0);
        lit("ev2 overrun", 0, 1, 2, 1);
        step(0, 1, 1);
        lit("clr+ack", 0, 0, 0, 0);
        ev_seq(0, 0);
        ev_seq(1, 0);
        lit("ev+ack", 0, 1, 2, 0);

        // Saturation, then clear coinciding with an event
        step(0, 1, 1);
        for (int i = 0; i < SAT + 1; i++) ev_seq(0, 0);
        lit("saturate", 0, 1, SAT, 1);
        ev_seq(0, 1);
        lit("clr+ev", 0, 1, 1, 0);

        // Async reset mid-qualification with an event pending
        repeat (2) step(1, 0, 0);
        async_rst("rst midq");
        repeat (3) step(1, 0, 0);
        lit("post rst pre", 0, 0, 0, 0);
        step(1, 0, 0);
        lit("post rst ev", 1, 1, 1, 0);

        // Async reset while HIGH with evt_valid set
        async_rst("rst high");
        repeat (S) step(0, 0, 0);
        lit("final", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flag_event_monitor.md
Name: flag_event_monitor

Overview:
Downstream consumer of the combinational flag logic output (out = x&y | y&z). It filters the raw flag and declares it stable only after a programmable number of consecutive identical samples. Each qualified rising transition is reported as an event through a valid/ack handshake, with a saturating event counter and a sticky overrun flag. All logic runs in the flag source's clock domain, so no synchronizer is used.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples required to qualify a level change (legal range ≥1)
CNT_W, 8, width of the event counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
flag_in  input  1  raw flag from the combinational flag logic, sampled every clk edge
clr_cnt  input  1  synchronous clear of evt_count and overrun
evt_ack  input  1  consumer acknowledge for evt_valid
flag_stable  output  1  filtered flag level, registered
evt_valid  output  1  a qualified rising event is pending
evt_count  output  CNT_W  saturating count of qualified rising events
overrun  output  1  sticky: an event arrived while the previous one was still unacknowledged

Behaviour:
- Reset: rst=1 forces, asynchronously, state=IDLE, qcnt=0, flag_stable=0, evt_valid=0, evt_count=0, overrun=0. Reset asserted mid-qualification or while evt_valid=1 discards all pending state; nothing is reported afterwards.
- FSM states:
  - IDLE: stable low.
  - RISE_Q: counting high samples.
  - HIGH: stable high.
  - FALL_Q: counting low samples.
- qcnt width is $clog2(STABLE_CYCLES+1). qcnt counts consecutive qualifying samples, including the current edge.
- IDLE:
  - flag_in=1 → RISE_Q with qcnt=1.
  - If STABLE_CYCLES==1, go directly IDLE → HIGH.
- RISE_Q:
  - flag_in=0 → IDLE, qcnt=0.
  - flag_in=1 → qcnt+1; on reaching STABLE_CYCLES → HIGH.
- HIGH:
  - flag_in=0 → FALL_Q with qcnt=1, or → IDLE directly if STABLE_CYCLES==1.
- FALL_Q:
  - flag_in=1 → HIGH with no new event.
  - flag_in=0 → qcnt+1; on reaching STABLE_CYCLES → IDLE.
- flag_stable=1 exactly when the state is HIGH or FALL_Q.
- Latency: if flag_in is high at edges k..k+S-1 (S=STABLE_CYCLES), flag_stable and evt_valid are 1 after edge k+S-1. The falling direction is symmetric for flag_stable.
- Event: generated on the edge of any transition into HIGH from IDLE or RISE_Q only. Re-entry to HIGH from FALL_Q is a filtered glitch and does not generate an event.
- On an event:
  - evt_valid ← 1.
  - evt_count ← evt_count+1, saturating at 2^CNT_W−1 (no wrap).
- Handshake:
  - evt_valid holds until evt_ack=1 is sampled while evt_valid=1; it clears on that edge.
  - evt_ack while evt_valid=0 is ignored.
- Simultaneous event and ack: evt_valid stays 1 (the new event is pending) and overrun is not set.
- Event while evt_valid=1 with no ack on the same edge: overrun ← 1 (sticky) and the count still increments.
- clr_cnt=1 sets evt_count ← 0 and overrun ← 0. If it coincides with an event: evt_count ← 1 and overrun ← 0.
- clr_cnt does not affect evt_valid, the FSM, or flag_stable.

Test Plan:
- S=4, CNT_W=8. Reset, then flag_in=1 for 3 cycles, then 0 → flag_stable=0, evt_valid=0, evt_count=0 throughout.
- flag_in=1 at edges 10–14 → flag_stable=1 and evt_valid=1 after edge 13, evt_count=1. Assert evt_ack at edge 16 → evt_valid=0 after edge 16.
- From HIGH: flag_in=0 for 3 edges, then 1 → flag_stable stays 1, no new event, count unchanged. Then flag_in=0 for 4 edges → flag_stable=0 after the 4th edge.
- Two qualified rising events with no ack → evt_count=2, overrun=1, evt_valid=1. Repeat with evt_ack asserted on the second event's edge → overrun=0, evt_valid=1.
- Preload 255 events (or force CNT_W=2 with 5 events) → evt_count saturates at 255 (or 3). Then clr_cnt on the same edge as a new event → evt_count=1, overrun=0.
- Assert rst asynchronously mid-RISE_Q (qcnt=2) and again with evt_valid=1 → all outputs 0 immediately, before the next clk edge. After release, a fresh 4-cycle high is needed to produce an event.
